sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Two-master, one-slave Avalon-MM arbiter in the `clk` domain that shares the single SDRAM controller port.
- Port 0 is the VGA display reader: read-only, pipelined, 8-word aligned bursts, latency-critical.
- Port 1 is the render/GPU master: reads and writes.
- Fixed priority to port 0, with a starvation guard for port 1. Tracks outstanding reads so `read_data_valid` is returned to the issuing port.

Parameters:
- MAX_PENDING, 16: max outstanding slave reads; depth of the tag FIFO (power of 2).
- STARVE_LIMIT, 64: consecutive port-0 accepts while port 1 waits before port 1 is promoted.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- m0_address  in  32  port-0 byte address
- m0_read  in  1  port-0 read request
- m0_wait_request  out  1  port-0 stall
- m0_read_data  out  32  port-0 read data
- m0_read_data_valid  out  1  port-0 data valid
- m1_address  in  32  port-1 byte address
- m1_read  in  1  port-1 read request
- m1_write  in  1  port-1 write request (never asserted together with m1_read)
- m1_write_data  in  32  port-1 write data
- m1_byte_enable  in  4  port-1 byte enables
- m1_wait_request  out  1  port-1 stall
- m1_read_data  out  32  port-1 read data
- m1_read_data_valid  out  1  port-1 data valid
- s_address  out  32  to SDRAM controller
- s_read  out  1  to SDRAM controller
- s_write  out  1  to SDRAM controller
- s_write_data  out  32  to SDRAM controller
- s_byte_enable  out  4  to SDRAM controller
- s_wait_request  in  1  from SDRAM controller
- s_read_data  in  32  from SDRAM controller
- s_read_data_valid  in  1  from SDRAM controller
- pending  out  5  outstanding read count, 0..MAX_PENDING (width $clog2(MAX_PENDING)+1)
- err_orphan  out  1  sticky: valid data arrived with no outstanding read

Behaviour:
- Reset:
  - State PRIO0; starve counter 0; tag FIFO empty; `pending`=0; `err_orphan`=0.
  - All `s_*` strobes 0; both `m*_wait_request`=1 only if requesting; both `m*_read_data_valid`=0.
- Eligibility (combinational each cycle):
  - full = (pending==MAX_PENDING).
  - e0 = m0_read && !full.
  - e1 = (m1_write) || (m1_read && !full).
- Selection (combinational, zero-latency pass-through):
  - PRIO0: sel=0 if e0, else sel=1 if e1, else none.
  - PRIO1: sel=1 if e1, else sel=0 if e0.
  - The selected master's address, read, write, write_data and byte_enable drive `s_*`; port 0 drives byte_enable 4'hF and write 0.
  - With no selection, `s_read`=`s_write`=0 and `s_address` holds the port-0 address.
- Wait request:
  - The selected port sees `m_wait_request` = s_wait_request.
  - A non-selected port sees 1 whenever it requests, and 0 when idle.
- Accept: a cycle where the selected strobe is high and `s_wait_request`=0.
- State machine:
  - PRIO0 -> PRIO1 when a port-0 accept occurs with starve counter ≥ STARVE_LIMIT-1 and m0_address[4:0]==5'h1C (last word of an 8-word burst). This never splits a display burst.
  - Starve counter increments on each port-0 accept while e1 is high. It clears on any port-1 accept, and on any cycle where e1=0.
  - PRIO1 -> PRIO0 on the first port-1 accept; the counter clears at the same time.
  - If port 1 drops its request while in PRIO1, return to PRIO0.
- Tag FIFO (1-bit port IDs, depth MAX_PENDING):
  - Push the selected port ID on every read accept.
  - Pop on `s_read_data_valid`.
  - Simultaneous push and pop leaves `pending` unchanged.
  - Writes are never tagged.
- Read return:
  - `s_read_data` is broadcast combinationally to both `m*_read_data`.
  - `m0_read_data_valid` = s_read_data_valid && !empty && head==0; `m1_read_data_valid` likewise for head==1. Zero latency.
- Orphan data: `s_read_data_valid` with the FIFO empty is dropped, no valid is raised, `err_orphan` is set and held until reset.
- Full FIFO: further reads are stalled; writes continue to pass.
- Reset mid-operation clears all state immediately. In-flight data arriving after reset is treated as orphan.

Test Plan:
- Port 0 alone reads 8 words from 0x100 with s_wait_request=0 and fixed latency 3 -> s_address 0x100..0x11C on consecutive cycles; 8 m0_read_data_valid; m1_read_data_valid never high.
- Port 0 and port 1 both read at cycle 0 -> port 0 is granted; m1_wait_request=1 until port 0 idles; returned data is routed in order to port 0 then port 1.
- Port 0 streams continuously and port 1 holds a write, STARVE_LIMIT=8 -> port 1 write is accepted on the cycle after the port-0 accept of address ..1C following ≥8 accepts; state then returns to PRIO0.
- Slave never returns data and 20 port-1 reads are issued, MAX_PENDING=16 -> exactly 16 accepted; pending=16; port-1 reads stall; a port-1 write issued meanwhile is still accepted.
- Interleaved returns with push and pop in the same cycle -> pending stays constant; data tags match issue order over 1000 random transactions against a scoreboard.
- s_read_data_valid pulsed with pending=0 -> no m*_read_data_valid; err_orphan=1 and stays set until resetn is asserted low.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Two-master to one-slave Avalon-MM arbiter in front of the SDRAM controller.
// Port 0 (display reader) has fixed priority; port 1 (render master) is promoted
// after a long run of port-0 accepts, but only at an 8-word burst boundary.
// A 1-bit tag FIFO remembers which port issued each outstanding read so that
// returning data is steered back to the right master in issue order.
module sdram_port_arbiter #(
    parameter int unsigned MAX_PENDING  = 16,
    parameter int unsigned STARVE_LIMIT = 64
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic [31:0]                    m0_address,
    input  logic                           m0_read,
    output logic                           m0_wait_request,
    output logic [31:0]                    m0_read_data,
    output logic                           m0_read_data_valid,
    input  logic [31:0]                    m1_address,
    input  logic                           m1_read,
    input  logic                           m1_write,
    input  logic [31:0]                    m1_write_data,
    input  logic [3:0]                     m1_byte_enable,
    output logic                           m1_wait_request,
    output logic [31:0]                    m1_read_data,
    output logic                           m1_read_data_valid,
    output logic [31:0]                    s_address,
    output logic                           s_read,
    output logic                           s_write,
    output logic [31:0]                    s_write_data,
    output logic [3:0]                     s_byte_enable,
    input  logic                           s_wait_request,
    input  logic [31:0]                    s_read_data,
    input  logic                           s_read_data_valid,
    output logic [$clog2(MAX_PENDING):0]   pending,
    output logic                           err_orphan
);

    localparam int unsigned PtrW    = $clog2(MAX_PENDING);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {StPrio0, StPrio1} state_t;

    state_t               state_q, state_d;
    logic [StarveW-1:0]   starve_q, starve_d;
    logic [MAX_PENDING-1:0] tag_mem_q;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q, count_d;
    logic                 err_orphan_q;

    logic full, empty, e0, e1;
    logic sel_valid, sel_id;
    logic accept, rd_accept, pop, orphan, head;

    assign full  = (count_q == CntW'(MAX_PENDING));
    assign empty = (count_q == '0);
    assign e0    = m0_read && !full;
    assign e1    = m1_write || (m1_read && !full);

    // Grant selection: fixed order depends on the current priority state.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = 1'b0;
        unique case (state_q)
            StPrio0: begin
                if (e0) begin
                    sel_valid = 1'b1;
                    sel_id    = 1'b0;
                end else if (e1) begin
                    sel_valid = 1'b1;
                    sel_id    = 1'b1;
                end
            end
            StPrio1: begin
                if (e1) begin
                    sel_valid = 1'b1;
                    sel_id    = 1'b1;
                end else if (e0) begin
                    sel_valid = 1'b1;
                    sel_id    = 1'b0;
                end
            end
        endcase
    end

    // Slave-side mux and master-side stalls, all zero-latency pass-through.
    always_comb begin
        s_address       = (sel_valid && sel_id) ? m1_address : m0_address;
        s_read          = sel_valid && (sel_id ? m1_read : m0_read);
        s_write         = sel_valid && sel_id && m1_write;
        s_write_data    = m1_write_data;
        s_byte_enable   = (sel_valid && sel_id) ? m1_byte_enable : 4'hF;
        m0_wait_request = (sel_valid && !sel_id) ? s_wait_request : m0_read;
        m1_wait_request = (sel_valid && sel_id) ? s_wait_request : (m1_read || m1_write);
    end

    assign accept    = sel_valid && !s_wait_request;
    assign rd_accept = accept && s_read;
    assign pop       = s_read_data_valid && !empty;
    assign orphan    = s_read_data_valid && empty;
    assign head      = tag_mem_q[rd_ptr_q];

    // Read return: data is broadcast, valid goes only to the tagged owner.
    always_comb begin
        m0_read_data       = s_read_data;
        m1_read_data       = s_read_data;
        m0_read_data_valid = pop && !head;
        m1_read_data_valid = pop && head;
    end

    // Priority FSM and starvation counter next-state.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        // Counter saturates at STARVE_LIMIT; only the >= LIMIT-1 test matters.
        if ((accept && sel_id) || !e1) begin
            starve_d = '0;
        end else if (accept && !sel_id && starve_q != StarveW'(STARVE_LIMIT)) begin
            starve_d = starve_q + 1'b1;
        end
        unique case (state_q)
            StPrio0: begin
                // Promote only on the last word of a display burst.
                if (accept && !sel_id && starve_q >= StarveW'(STARVE_LIMIT - 1) &&
                    m0_address[4:0] == 5'h1C) begin
                    state_d = StPrio1;
                end
            end
            StPrio1: begin
                if ((accept && sel_id) || !e1) begin
                    state_d = StPrio0;
                end
            end
        endcase
    end

    // Outstanding-read count; push and pop together cancel.
    always_comb begin
        count_d = count_q;
        unique case ({rd_accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers, tag FIFO storage/pointers and sticky orphan flag.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StPrio0;
            starve_q     <= '0;
            tag_mem_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            count_q  <= count_d;
            if (rd_accept) begin
                tag_mem_q[wr_ptr_q] <= sel_id;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (orphan) begin
                err_orphan_q <= 1'b1;
            end
        end
    end

    assign pending    = count_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter. A queue-based reference model
// derives grants, stalls, read routing, pending count and the orphan flag
// from the arbitration rules; a simple in-order slave returns read data.
module tb_sdram_port_arbiter;

    localparam int unsigned MAXP  = 16;
    localparam int unsigned LIMIT = 8;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] m0_address = '0;
    logic        m0_read = 1'b0;
    logic        m0_wait_request;
    logic [31:0] m0_read_data;
    logic        m0_read_data_valid;
    logic [31:0] m1_address = '0;
    logic        m1_read = 1'b0;
    logic        m1_write = 1'b0;
    logic [31:0] m1_write_data = '0;
    logic [3:0]  m1_byte_enable = '0;
    logic        m1_wait_request;
    logic [31:0] m1_read_data;
    logic        m1_read_data_valid;
    logic [31:0] s_address;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_write_data;
    logic [3:0]  s_byte_enable;
    logic        s_wait_request = 1'b0;
    logic [31:0] s_read_data = '0;
    logic        s_read_data_valid = 1'b0;
    logic [4:0]  pending;
    logic        err_orphan;

    sdram_port_arbiter #(
        .MAX_PENDING (MAXP),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .m0_address        (m0_address),
        .m0_read           (m0_read),
        .m0_wait_request   (m0_wait_request),
        .m0_read_data      (m0_read_data),
        .m0_read_data_valid(m0_read_data_valid),
        .m1_address        (m1_address),
        .m1_read           (m1_read),
        .m1_write          (m1_write),
        .m1_write_data     (m1_write_data),
        .m1_byte_enable    (m1_byte_enable),
        .m1_wait_request   (m1_wait_request),
        .m1_read_data      (m1_read_data),
        .m1_read_data_valid(m1_read_data_valid),
        .s_address         (s_address),
        .s_read            (s_read),
        .s_write           (s_write),
        .s_write_data      (s_write_data),
        .s_byte_enable     (s_byte_enable),
        .s_wait_request    (s_wait_request),
        .s_read_data       (s_read_data),
        .s_read_data_valid (s_read_data_valid),
        .pending           (pending),
        .err_orphan        (err_orphan)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    bit prio1;
    int starve;
    bit tags[$];
    bit orphan_m;
    int promotions;
    int m1_reads_issued;

    // Stimulus state: master requests are held until the model sees them accepted.
    bit          m0_busy;
    int          m0_idx;
    logic [31:0] m0_base;
    bit          m1_hold;

    function automatic bit roll(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic model_clear();
        prio1    = 1'b0;
        starve   = 0;
        tags     = {};
        orphan_m = 1'b0;
        m0_busy  = 1'b0;
        m1_hold  = 1'b0;
    endtask

    task automatic step(input int p_m0, input int p_m1, input int p_wr, input int p_wait,
                        input int p_rdv, input bit force_orphan);
        bit full, e0, e1, acc, exp_rd, exp_wr, exp_v0, exp_v1;
        int sel;
        logic [31:0] exp_addr;
        @(negedge clk);
        if (!m0_busy && roll(p_m0)) begin
            m0_busy = 1'b1;
            m0_idx  = 0;
            m0_base = $urandom & 32'hFFFF_FFE0;
        end
        m0_read    = m0_busy;
        m0_address = m0_base + 32'(m0_idx * 4);
        if (!m1_hold) begin
            if (roll(p_m1)) begin
                m1_hold        = 1'b1;
                m1_write       = roll(p_wr);
                m1_read        = !m1_write;
                m1_address     = $urandom;
                m1_write_data  = $urandom;
                m1_byte_enable = 4'($urandom);
            end else begin
                m1_read  = 1'b0;
                m1_write = 1'b0;
            end
        end
        s_wait_request    = roll(p_wait);
        s_read_data       = $urandom;
        s_read_data_valid = force_orphan || (tags.size() > 0 && roll(p_rdv));
        #1;

        full = (tags.size() == MAXP);
        e0   = m0_read && !full;
        e1   = m1_write || (m1_read && !full);
        if (!prio1) sel = e0 ? 0 : (e1 ? 1 : -1);
        else        sel = e1 ? 1 : (e0 ? 0 : -1);
        exp_rd   = (sel == 0) || (sel == 1 && m1_read);
        exp_wr   = (sel == 1) && m1_write;
        exp_addr = (sel == 1) ? m1_address : m0_address;
        exp_v0   = s_read_data_valid && tags.size() > 0 && tags[0] == 1'b0;
        exp_v1   = s_read_data_valid && tags.size() > 0 && tags[0] == 1'b1;

        check("s_read", s_read, exp_rd);
        check("s_write", s_write, exp_wr);
        check("s_address", s_address, exp_addr);
        if (sel == 0) check("s_byte_enable_p0", s_byte_enable, 4'hF);
        if (sel == 1) check("s_byte_enable_p1", s_byte_enable, m1_byte_enable);
        if (exp_wr) check("s_write_data", s_write_data, m1_write_data);
        check("m0_wait", m0_wait_request, (sel == 0) ? s_wait_request : m0_read);
        check("m1_wait", m1_wait_request, (sel == 1) ? s_wait_request : (m1_read | m1_write));
        check("m0_rdv", m0_read_data_valid, exp_v0);
        check("m1_rdv", m1_read_data_valid, exp_v1);
        if (exp_v0) check("m0_read_data", m0_read_data, s_read_data);
        if (exp_v1) check("m1_read_data", m1_read_data, s_read_data);
        check("pending", pending, tags.size());
        check("err_orphan", err_orphan, orphan_m);

        // Advance the model to the state after the coming rising edge.
        acc = (sel != -1) && !s_wait_request;
        if (s_read_data_valid) begin
            if (tags.size() > 0) void'(tags.pop_front());
            else orphan_m = 1'b1;
        end
        if (acc && exp_rd) begin
            tags.push_back(sel == 1);
            if (sel == 1) m1_reads_issued++;
        end
        if (!prio1) begin
            if (acc && sel == 0 && starve >= LIMIT - 1 && m0_address[4:0] == 5'h1C) begin
                prio1 = 1'b1;
                promotions++;
            end
        end else if ((acc && sel == 1) || !e1) begin
            prio1 = 1'b0;
        end
        if ((acc && sel == 1) || !e1) starve = 0;
        else if (acc && sel == 0) starve++;
        if (acc && sel == 0) begin
            m0_idx++;
            if (m0_idx == 8) m0_busy = 1'b0;
        end
        if (acc && sel == 1) m1_hold = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn            = 1'b0;
        m0_read           = 1'b0;
        m1_read           = 1'b0;
        m1_write          = 1'b0;
        s_read_data_valid = 1'b0;
        s_wait_request    = 1'b0;
        #1;
        check("rst_pending", pending, 0);
        check("rst_err_orphan", err_orphan, 0);
        check("rst_s_read", s_read, 0);
        check("rst_s_write", s_write, 0);
        check("rst_m0_wait_idle", m0_wait_request, 0);
        check("rst_m1_wait_idle", m1_wait_request, 0);
        check("rst_m0_rdv", m0_read_data_valid, 0);
        check("rst_m1_rdv", m1_read_data_valid, 0);
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        promotions      = 0;
        m1_reads_issued = 0;
        model_clear();
        repeat (2) @(negedge clk);
        do_reset();

        // Mixed traffic with random stalls and returns.
        repeat (1500) step(50, 50, 50, 20, 50, 1'b0);
        // Slave returns rarely: FIFO fills, port-1 reads stall, writes still pass.
        repeat (400) step(30, 90, 30, 10, 3, 1'b0);
        // Display streams back-to-back while port 1 mostly writes: starvation guard.
        repeat (600) step(100, 100, 90, 0, 95, 1'b0);
        repeat (800) step(50, 50, 50, 20, 50, 1'b0);

        // Reset with reads in flight; the late return is an orphan.
        do_reset();
        step(0, 0, 0, 0, 0, 1'b1);
        repeat (50) step(0, 0, 0, 0, 0, 1'b0);
        check("orphan_sticky", err_orphan, 1);
        do_reset();
        repeat (200) step(50, 50, 50, 20, 50, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
